branch_stack: RTL

- Checkpoint stack for the R10K rename path.
- Takes a free-list snapshot when dispatch sends a branch. Restores the free list one cycle after that branch resolves as mispredicted, and discards all younger checkpoints at the same time.
- Sits upstream of the free/complete-list block, driving its free_list_restore and restore_flag inputs.
- Also supplies the live branch mask that dispatch uses to tag instructions.

---
 rtl/branch_stack.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_stack.sv
// Checkpoint stack for the rename path: snapshots the free list per in-flight branch
// and restores it one cycle after a mispredict, squashing all younger checkpoints.
module branch_stack #(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_SZ   = 64,
  parameter int N             = 3,
  parameter int PHYS_IDX_BITS = 6,
  parameter int CNT_BITS      = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push_valid,
  input  logic [PHYS_REG_SZ-1:0]             push_free_list,
  output logic [DEPTH-1:0]                   alloc_tag,
  output logic                               full,
  output logic [DEPTH-1:0]                   branch_mask,
  input  logic                               resolve_valid,
  input  logic [DEPTH-1:0]                   resolve_tag,
  input  logic                               resolve_mispredict,
  input  logic [N-1:0][PHYS_IDX_BITS-1:0]    phys_reg_retiring,
  input  logic [CNT_BITS-1:0]                num_retiring_valid,
  output logic [PHYS_REG_SZ-1:0]             free_list_restore,
  output logic                               restore_flag
);

  function automatic logic is_onehot(input logic [DEPTH-1:0] v);
    return (v != {DEPTH{1'b0}}) && ((v & (v - DEPTH'(1))) == {DEPTH{1'b0}});
  endfunction

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PHYS_REG_SZ-1:0] snap_q [DEPTH];
  logic [PHYS_REG_SZ-1:0] snap_d [DEPTH];
  logic [DEPTH-1:0]       dep_q  [DEPTH];
  logic [DEPTH-1:0]       dep_d  [DEPTH];
  logic                   restore_flag_q, restore_flag_d;
  logic [PHYS_REG_SZ-1:0] free_list_restore_q, free_list_restore_d;

  logic [PHYS_REG_SZ-1:0] retire_bits_s;
  logic [PHYS_REG_SZ-1:0] sel_snap_s;
  logic [DEPTH-1:0]       alloc_s;
  logic [DEPTH-1:0]       correct_clr_s;
  logic                   found_s, hit_s, correct_s, mispredict_s, push_ok_s;

  // Registers freed by retirement this cycle, one-hot per valid lane.
  always_comb begin
    retire_bits_s = {PHYS_REG_SZ{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (32'(num_retiring_valid) > i) begin
        retire_bits_s[phys_reg_retiring[i]] = 1'b1;
      end else begin
        retire_bits_s = retire_bits_s;
      end
    end
  end

  // Lowest free slot, resolve qualification and the snapshot selected by the resolve tag.
  always_comb begin
    alloc_s    = {DEPTH{1'b0}};
    found_s    = 1'b0;
    sel_snap_s = {PHYS_REG_SZ{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found_s) begin
        alloc_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
      if (resolve_tag[i]) begin
        sel_snap_s = sel_snap_s | snap_q[i];
      end else begin
        sel_snap_s = sel_snap_s;
      end
    end
    hit_s         = resolve_valid && is_onehot(resolve_tag) && ((resolve_tag & valid_q) != {DEPTH{1'b0}});
    correct_s     = hit_s && !resolve_mispredict;
    mispredict_s  = hit_s && resolve_mispredict;
    correct_clr_s = correct_s ? resolve_tag : {DEPTH{1'b0}};
    push_ok_s     = push_valid && !(&valid_q) && !mispredict_s;
  end

  // Next-state of every checkpoint slot and of the restore outputs.
  always_comb begin
    valid_d             = valid_q;
    restore_flag_d      = mispredict_s;
    free_list_restore_d = mispredict_s ? (sel_snap_s | retire_bits_s) : free_list_restore_q;
    for (int i = 0; i < DEPTH; i++) begin
      snap_d[i] = valid_q[i] ? (snap_q[i] | retire_bits_s) : snap_q[i];
      dep_d[i]  = dep_q[i] & ~correct_clr_s;
      if (correct_clr_s[i]) begin
        valid_d[i] = 1'b0;
      end else if (mispredict_s && (resolve_tag[i] || ((dep_q[i] & resolve_tag) != {DEPTH{1'b0}}))) begin
        valid_d[i] = 1'b0;
      end else if (push_ok_s && alloc_s[i]) begin
        valid_d[i] = 1'b1;
        snap_d[i]  = push_free_list | retire_bits_s;
        dep_d[i]   = valid_q & ~correct_clr_s;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q             <= {DEPTH{1'b0}};
      restore_flag_q      <= 1'b0;
      free_list_restore_q <= {PHYS_REG_SZ{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        snap_q[i] <= {PHYS_REG_SZ{1'b0}};
        dep_q[i]  <= {DEPTH{1'b0}};
      end
    end else begin
      valid_q             <= valid_d;
      restore_flag_q      <= restore_flag_d;
      free_list_restore_q <= free_list_restore_d;
      for (int i = 0; i < DEPTH; i++) begin
        snap_q[i] <= snap_d[i];
        dep_q[i]  <= dep_d[i];
      end
    end
  end

  assign alloc_tag         = alloc_s;
  assign full              = &valid_q;
  assign branch_mask       = valid_q;
  assign restore_flag      = restore_flag_q;
  assign free_list_restore = free_list_restore_q;

endmodule
